// File: rtl/axi_lite_master_if.sv
// Bundles the command/response side and the five AXI-lite channels of axi_lite_master.
// The master modport is the block's own view; the slave modport is the view of whatever drives it.
interface axi_lite_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  // Every channel follows valid/ready: a transfer happens on the rising edge where both are high.
  // The source keeps valid and its payload stable until then, and the sink may raise ready at any time.
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_wstrb;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_resp;
  logic [15:0]       err_count;

  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp, err_count,
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp, err_count,
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready
  );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-lite master: turns one command into one AXI-lite read or write
// and returns one response, counting non-OKAY responses in a saturating counter.
module axi_lite_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                aclk,
  input  logic                areset_n,
  axi_lite_master_if.master   bus,
  output logic [2:0]          dbg_state
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic              init_q;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              rsp_write_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [1:0]        rsp_resp_q;
  logic [15:0]       err_q;

  logic cmd_accept, b_fire, r_fire;
  logic aw_hs, w_hs;
  logic awvalid_c, wvalid_c, arvalid_c;
  logic err_hit;

  // Request valids come from registered state only, so they cannot glitch or drop before their handshake.
  assign awvalid_c = (state_q == WR_REQ) && !aw_done_q;
  assign wvalid_c  = (state_q == WR_REQ) && !w_done_q;
  assign arvalid_c = (state_q == RD_REQ);

  always_comb begin
    state_d    = state_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    cmd_accept = 1'b0;
    b_fire     = 1'b0;
    r_fire     = 1'b0;
    aw_hs      = 1'b0;
    w_hs       = 1'b0;
    case (state_q)
      IDLE: begin
        if (init_q && bus.cmd_valid) begin
          cmd_accept = 1'b1;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          state_d    = bus.cmd_write ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        aw_hs = awvalid_c && bus.awready;
        w_hs  = wvalid_c && bus.wready;
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (bus.bvalid) begin
          b_fire  = 1'b1;
          state_d = RESP;
        end
      end
      RD_REQ: begin
        if (bus.arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (bus.rvalid) begin
          r_fire  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign err_hit = (b_fire && (bus.bresp != 2'b00)) || (r_fire && (bus.rresp != 2'b00));

  // init_q holds cmd_ready low through reset and releases it on the first edge afterwards.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q   <= IDLE;
      init_q    <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      init_q    <= 1'b1;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (cmd_accept) begin
      addr_q  <= bus.cmd_addr;
      wdata_q <= bus.cmd_wdata;
      wstrb_q <= bus.cmd_wstrb;
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
    end else if (b_fire) begin
      rsp_write_q <= 1'b1;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= bus.bresp;
    end else if (r_fire) begin
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= bus.rdata;
      rsp_resp_q  <= bus.rresp;
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      err_q <= '0;
    end else if (err_hit && (err_q != 16'hFFFF)) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE) && init_q;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_resp  = rsp_resp_q;
  assign bus.err_count = err_q;

  // Channel payloads read as zero whenever their valid is low.
  assign bus.awvalid = awvalid_c;
  assign bus.awaddr  = awvalid_c ? addr_q : '0;
  assign bus.wvalid  = wvalid_c;
  assign bus.wdata   = wvalid_c ? wdata_q : '0;
  assign bus.wstrb   = wvalid_c ? wstrb_q : '0;
  assign bus.bready  = (state_q == WR_RESP);
  assign bus.arvalid = arvalid_c;
  assign bus.araddr  = arvalid_c ? addr_q : '0;
  assign bus.rready  = (state_q == RD_DATA);

  assign dbg_state = state_q;
endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: tasks play command source and AXI-lite slave,
// a monitor pops expected responses from a queue whenever a response is consumed.
module tb_axi_lite_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic       aclk = 1'b0;
  logic       areset_n = 1'b0;
  logic [2:0] dbg_state;

  always #5 aclk = ~aclk;

  axi_lite_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  axi_lite_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .aclk      (aclk),
    .areset_n  (areset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Expected response: {rsp_write, rsp_resp, rsp_rdata}
  logic [DW+2:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: samples 2 ns after the falling edge, once the drivers have settled.
  always @(negedge aclk) begin
    logic [DW+2:0] e;
    #2;
    if (areset_n && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_write", 64'(bus.rsp_write), 64'(e[DW+2]));
        check("rsp_resp",  64'(bus.rsp_resp),  64'(e[DW+1:DW]));
        check("rsp_rdata", 64'(bus.rsp_rdata), 64'(e[DW-1:0]));
      end
    end
  end

  // Called at a falling edge; returns one falling edge after the accepting rising edge.
  task automatic send_cmd(input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input logic [SW-1:0] strb);
    logic ok;
    ok = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = data;
    bus.cmd_wstrb = strb;
    for (int i = 0; i < 20; i++) begin
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge aclk);
    end
    if (!ok) check("cmd_accept_timeout", 64'd0, 64'd1);
    @(negedge aclk);
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = AW'($urandom);
    bus.cmd_wdata = DW'($urandom);
    bus.cmd_wstrb = '0;
  endtask

  // AW and W slave with independent ready delays, counted in cycles from the first request cycle.
  task automatic serve_aw_w(input int aw_dly, input int w_dly, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input logic [SW-1:0] strb);
    logic aw_done, w_done, aw_hs, w_hs;
    aw_done = 1'b0;
    w_done  = 1'b0;
    for (int c = 0; c < 40 && !(aw_done && w_done); c++) begin
      if (w_done && !aw_done) begin
        check("wvalid_drop", 64'(bus.wvalid), 64'd0);
        check("awvalid_hold", 64'(bus.awvalid), 64'd1);
      end
      if (aw_done && !w_done) begin
        check("awvalid_drop", 64'(bus.awvalid), 64'd0);
        check("wvalid_hold", 64'(bus.wvalid), 64'd1);
      end
      if (bus.awvalid) check("awaddr", 64'(bus.awaddr), 64'(addr));
      if (bus.wvalid) begin
        check("wdata", 64'(bus.wdata), 64'(data));
        check("wstrb", 64'(bus.wstrb), 64'(strb));
      end
      bus.awready = (c >= aw_dly);
      bus.wready  = (c >= w_dly);
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      @(negedge aclk);
      if (aw_hs) aw_done = 1'b1;
      if (w_hs)  w_done  = 1'b1;
    end
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    if (!(aw_done && w_done)) check("aw_w_timeout", 64'd0, 64'd1);
    check("bready_rise", 64'(bus.bready), 64'd1);
    check("state_wr_resp", 64'(dbg_state), 64'd2);
    check("aw_w_valids_low", 64'({bus.awvalid, bus.wvalid}), 64'd0);
  endtask

  task automatic serve_b(input int b_dly, input logic [1:0] resp);
    logic hs;
    hs = 1'b0;
    for (int c = 0; c < 40; c++) begin
      bus.bvalid = (c >= b_dly);
      bus.bresp  = resp;
      hs = bus.bvalid && bus.bready;
      @(negedge aclk);
      if (hs) break;
    end
    bus.bvalid = 1'b0;
    bus.bresp  = 2'b00;
    if (!hs) check("b_timeout", 64'd0, 64'd1);
  endtask

  task automatic serve_read(input int ar_dly, input int r_dly, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input logic [1:0] resp);
    logic hs;
    hs = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.arvalid) check("araddr", 64'(bus.araddr), 64'(addr));
      bus.arready = (c >= ar_dly);
      hs = bus.arvalid && bus.arready;
      @(negedge aclk);
      if (hs) break;
    end
    bus.arready = 1'b0;
    if (!hs) check("ar_timeout", 64'd0, 64'd1);
    hs = 1'b0;
    for (int c = 0; c < 40; c++) begin
      bus.rvalid = (c >= r_dly);
      bus.rdata  = data;
      bus.rresp  = resp;
      hs = bus.rvalid && bus.rready;
      @(negedge aclk);
      if (hs) break;
    end
    bus.rvalid = 1'b0;
    bus.rdata  = '0;
    bus.rresp  = 2'b00;
    if (!hs) check("r_timeout", 64'd0, 64'd1);
  endtask

  // Waits for rsp_valid, holds rsp_ready low for 'hold' cycles, then consumes the response.
  task automatic take_rsp(input int hold, output int waited);
    logic [DW+2:0] p;
    waited = 0;
    while (!bus.rsp_valid && waited < 40) begin
      @(negedge aclk);
      waited++;
    end
    if (!bus.rsp_valid) check("rsp_timeout", 64'd0, 64'd1);
    p = {bus.rsp_write, bus.rsp_resp, bus.rsp_rdata};
    for (int i = 0; i < hold; i++) begin
      bus.rsp_ready = 1'b0;
      @(negedge aclk);
      check("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      check("bp_payload", 64'({bus.rsp_write, bus.rsp_resp, bus.rsp_rdata}), 64'(p));
      check("bp_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    bus.cmd_valid = 1'b1;
    check("no_accept_on_rsp", 64'(bus.cmd_ready), 64'd0);
    @(negedge aclk);
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b0;
    check("idle_after_rsp", 64'(dbg_state), 64'd0);
    check("cmd_ready_after_rsp", 64'(bus.cmd_ready), 64'd1);
  endtask

  initial begin
    int w;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
    bus.cmd_wdata = '0;   bus.cmd_wstrb = '0;   bus.rsp_ready = 1'b0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;    bus.rresp = 2'b00;

    // Reset values
    repeat (3) @(negedge aclk);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    check("rst_valids", 64'({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, bus.rsp_valid}), 64'd0);
    check("rst_err_count", 64'(bus.err_count), 64'd0);
    check("rst_payloads", 64'(bus.awaddr | bus.araddr | bus.wdata | bus.rsp_rdata), 64'd0);
    areset_n = 1'b1;
    #1;
    check("cmd_ready_before_edge", 64'(bus.cmd_ready), 64'd0);
    @(negedge aclk);
    check("cmd_ready_first_edge", 64'(bus.cmd_ready), 64'd1);

    // Stray slave responses while idle are ignored
    bus.bvalid = 1'b1; bus.bresp = 2'b10; bus.rvalid = 1'b1; bus.rresp = 2'b11;
    bus.arready = 1'b1; bus.awready = 1'b1; bus.wready = 1'b1;
    repeat (3) @(negedge aclk);
    check("stray_state_idle", 64'(dbg_state), 64'd0);
    check("stray_err_count", 64'(bus.err_count), 64'd0);
    bus.bvalid = 1'b0; bus.bresp = 2'b00; bus.rvalid = 1'b0; bus.rresp = 2'b00;
    bus.arready = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0;

    // Zero-wait read
    exp_q.push_back({1'b0, 2'b00, 32'hDEADBEEF});
    send_cmd(1'b0, 32'h10, 32'h0, 4'h0);
    serve_read(0, 0, 32'h10, 32'hDEADBEEF, 2'b00);
    take_rsp(0, w);
    check("rd_latency", 64'(3 + w), 64'd3);
    check("rd_err_count", 64'(bus.err_count), 64'd0);

    // Write with awready two cycles after wready
    exp_q.push_back({1'b1, 2'b00, 32'h0});
    send_cmd(1'b1, 32'h4, 32'hA5A5A5A5, 4'hF);
    serve_aw_w(2, 0, 32'h4, 32'hA5A5A5A5, 4'hF);
    serve_b(0, 2'b00);
    take_rsp(0, w);

    // Same-cycle AW/W, zero-wait slave
    exp_q.push_back({1'b1, 2'b00, 32'h0});
    send_cmd(1'b1, 32'h100, 32'h12345678, 4'h3);
    serve_aw_w(0, 0, 32'h100, 32'h12345678, 4'h3);
    serve_b(0, 2'b00);
    take_rsp(0, w);
    check("wr_latency", 64'(3 + w), 64'd3);

    // AW first, W three cycles later, delayed B
    exp_q.push_back({1'b1, 2'b00, 32'h0});
    send_cmd(1'b1, 32'hFFFF_FFFC, 32'h0000_00C3, 4'h1);
    serve_aw_w(0, 3, 32'hFFFF_FFFC, 32'h0000_00C3, 4'h1);
    serve_b(2, 2'b00);
    take_rsp(0, w);

    // Slow read slave
    exp_q.push_back({1'b0, 2'b00, 32'h0BADF00D});
    send_cmd(1'b0, 32'h8000_0020, 32'h0, 4'h0);
    serve_read(3, 2, 32'h8000_0020, 32'h0BADF00D, 2'b00);
    take_rsp(0, w);

    // Error responses: SLVERR read then DECERR write
    exp_q.push_back({1'b0, 2'b10, 32'h1111_2222});
    send_cmd(1'b0, 32'h44, 32'h0, 4'h0);
    serve_read(0, 0, 32'h44, 32'h1111_2222, 2'b10);
    take_rsp(0, w);
    check("err_count_1", 64'(bus.err_count), 64'd1);
    exp_q.push_back({1'b1, 2'b11, 32'h0});
    send_cmd(1'b1, 32'h48, 32'h5555_AAAA, 4'hC);
    serve_aw_w(1, 1, 32'h48, 32'h5555_AAAA, 4'hC);
    serve_b(1, 2'b11);
    take_rsp(0, w);
    check("err_count_2", 64'(bus.err_count), 64'd2);

    // Backpressure on the response side
    exp_q.push_back({1'b0, 2'b00, 32'hCAFE_0001});
    send_cmd(1'b0, 32'h200, 32'h0, 4'h0);
    serve_read(0, 1, 32'h200, 32'hCAFE_0001, 2'b00);
    take_rsp(5, w);

    // Saturation from a preloaded full counter
    force dut.err_q = 16'hFFFF;
    @(negedge aclk);
    release dut.err_q;
    check("err_preload", 64'(bus.err_count), 64'hFFFF);
    exp_q.push_back({1'b0, 2'b10, 32'h0});
    send_cmd(1'b0, 32'h300, 32'h0, 4'h0);
    serve_read(0, 0, 32'h300, 32'h0, 2'b10);
    take_rsp(0, w);
    check("err_saturate", 64'(bus.err_count), 64'hFFFF);

    // Reset while waiting for B abandons the write
    send_cmd(1'b1, 32'h400, 32'h7777_7777, 4'hF);
    serve_aw_w(0, 0, 32'h400, 32'h7777_7777, 4'hF);
    areset_n = 1'b0;
    #1;
    check("rst_mid_valids", 64'({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, bus.rsp_valid}), 64'd0);
    check("rst_mid_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    check("rst_mid_err_count", 64'(bus.err_count), 64'd0);
    @(negedge aclk);
    areset_n = 1'b1;
    @(negedge aclk);
    check("rst_mid_idle", 64'(bus.cmd_ready), 64'd1);
    exp_q.push_back({1'b0, 2'b00, 32'h600D_600D});
    send_cmd(1'b0, 32'h10, 32'h0, 4'h0);
    serve_read(0, 0, 32'h10, 32'h600D_600D, 2'b00);
    take_rsp(0, w);
    check("post_rst_latency", 64'(3 + w), 64'd3);

    repeat (2) @(negedge aclk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axi_lite_master.md
AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning AXI-lite address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning AXI-lite data width (STRB_W = DATA_W/8).
REQ-003 SHALL have ports:
- aclk  in  1  clock; all logic on rising edge.
- areset_n  in  1  reset; asynchronous assert, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- cmd_wstrb  in  STRB_W  write byte strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when high with rsp_valid.
- rsp_write  out  1  response belongs to a write.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_resp  out  2  AXI response code (BRESP or RRESP).
- err_count  out  16  count of non-OKAY responses.
- awaddr, awvalid, awready (in), wdata, wstrb, wvalid, wready (in), bresp (in), bvalid (in), bready, araddr, arvalid, arready (in), rdata (in), rresp (in), rvalid (in), rready: AXI-lite master channels, widths per ADDR_W/DATA_W/STRB_W/2/1.

Function
REQ-004 SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP.
REQ-005 SHALL assert cmd_ready only in IDLE; a command is accepted on the cycle cmd_valid && cmd_ready.
REQ-006 On accept, SHALL register cmd_addr, cmd_wdata and cmd_wstrb, and go to WR_REQ if cmd_write=1, else RD_REQ.
REQ-007 In WR_REQ, SHALL drive awvalid and wvalid together from the first cycle.
REQ-008 In WR_REQ, SHALL drop awvalid from the cycle after the AW handshake and wvalid from the cycle after the W handshake, independently.
REQ-009 In WR_REQ, SHALL accept AW and W handshakes in the same cycle or in either order.
REQ-010 SHALL move WR_REQ -> WR_RESP on the cycle both handshakes are complete, including a same-cycle completion.
REQ-011 SHALL assert bready only in WR_RESP; on bvalid && bready it SHALL capture bresp, set rsp_write=1 and rsp_rdata=0, and go to RESP.
REQ-012 In RD_REQ, SHALL assert arvalid with the registered address; on arvalid && arready it SHALL go to RD_DATA.
REQ-013 SHALL assert rready only in RD_DATA; on rvalid && rready it SHALL capture rdata and rresp, set rsp_write=0, and go to RESP.
REQ-014 In RESP, SHALL hold rsp_valid=1 with stable payload until rsp_ready, then return to IDLE.
REQ-015 SHALL not accept a new command in the cycle rsp_ready is seen; the next accept is no earlier than the following cycle.
REQ-016 Once a valid (awvalid, wvalid, arvalid) is asserted, SHALL keep it and its payload stable until its handshake completes.
REQ-017 SHALL drive awaddr, araddr, wdata and wstrb from the registered command, and hold them at 0 when their channel's valid is low.
REQ-018 SHALL increment err_count in the cycle a B or R response with resp != 2'b00 is captured.
REQ-019 SHALL saturate err_count at 16'hFFFF.
REQ-020 SHALL ignore bvalid/rvalid outside WR_RESP/RD_DATA and awready/wready/arready outside the matching request state.
REQ-021 SHALL give minimum latency, with a zero-wait slave, of accept-to-rsp_valid 3 cycles for reads and 3 cycles for writes.

Reset
REQ-022 While areset_n=0, SHALL force state IDLE and clear all registered command, response and err_count state.
REQ-023 While areset_n=0, SHALL drive all outputs 0 except cmd_ready, which SHALL also be 0.
REQ-024 SHALL assert cmd_ready in the first rising edge after areset_n deasserts.
REQ-025 Reset mid-transaction SHALL abandon the transaction with no response and no err_count change.

Verification
REQ-026 Read: cmd read addr 0x10, slave arready=1, rvalid with rdata=0xDEADBEEF, rresp=0 -> rsp_valid with rsp_rdata=0xDEADBEEF, rsp_resp=0, rsp_write=0; err_count stays 0.
REQ-027 Write skew: cmd write addr 0x4, data 0xA5A5A5A5, strb 0xF; awready 2 cycles after wready -> wvalid drops after W handshake while awvalid stays high; single B -> rsp_write=1, rsp_resp=0.
REQ-028 Same-cycle AW/W handshake -> exactly one transition to WR_RESP; bready rises the next cycle.
REQ-029 Error: rresp=2'b10, then bresp=2'b11 -> err_count=1, then err_count=2; preload 16'hFFFF plus one error -> stays 16'hFFFF.
REQ-030 Backpressure: rsp_ready held low 5 cycles -> payload stable and cmd_ready=0 throughout; accept only after release.
REQ-031 Reset asserted while in WR_RESP -> all valids 0 immediately; after release, a new read completes normally.
